// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier controller.
package shift_add_mult_ctrl_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter width able to hold the values 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_adder.sv
// N-bit ripple-carry adder built from full-adder cells; carry-in is tied low.
module ripple_adder_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[N];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential N x N -> 2N unsigned shift-and-add multiplier sharing one ripple adder.
// Define MULT_EARLY_TERM_EN to finish early once the remaining multiplier bits are zero.
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int                CNT_W    = cnt_w(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_e             state_q, state_d;
    logic [N-1:0]       mcand_q, mcand_d;
    // P = {acc, mplr}; the carry slot above acc is always zero between cycles.
    logic [2*N-1:0]     p_q, p_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]     product_q, product_d;

    logic [N-1:0]       addend;
    logic [N-1:0]       sum;
    logic               cout;
    logic [2*N-1:0]     p_shift;

    assign addend = p_q[0] ? mcand_q : '0;

    ripple_adder_n #(.N(N)) u_adder (
        .a_i    (p_q[2*N-1:N]),
        .b_i    (addend),
        .sum_o  (sum),
        .cout_o (cout)
    );

    assign p_shift = {cout, sum, p_q[N-1:1]};

`ifdef MULT_EARLY_TERM_EN
    localparam logic [CNT_W-1:0] CNT_N = CNT_W'(N);

    logic [N-1:0]   rem_mask;
    logic           rem_zero;
    logic [2*N-1:0] p_align;

    // Low N-count bits of P are the multiplier bits not yet consumed.
    assign rem_mask = {N{1'b1}} >> cnt_q;
    assign rem_zero = ((p_q[N-1:0] & rem_mask) == '0) && (cnt_q < CNT_N);
    assign p_align  = p_q >> (CNT_N - cnt_q);
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = a;
                    p_d     = {{N{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
`ifdef MULT_EARLY_TERM_EN
                if (rem_zero) begin
                    product_d = p_align;
                    state_d   = DONE;
                end else begin
`else
                begin
`endif
                    p_d   = p_shift;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        product_d = p_shift;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == RUN) || (state_q == DONE);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Randomised scoreboard bench for shift_add_mult_ctrl (N=4); honours MULT_EARLY_TERM_EN.
module tb_shift_add_mult_ctrl;

    localparam int N = 4;
    localparam int W = 2 * N;
`ifdef MULT_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] product;

    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [W-1:0] last_prod = '0;
    bit           mon_en = 1'b0;
    logic [W-1:0] mon_e;
    int           mon_ec;

    shift_add_mult_ctrl #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Number of RUN cycles: full N, or (highest set bit index + 2) when early termination applies.
    function automatic int run_len(input logic [N-1:0] bv);
        int h;
        h = 0;
        for (int i = 0; i < N; i++) if (bv[i]) h = i + 1;
        return (EARLY && h < N) ? h + 1 : N;
    endfunction

    function automatic void push_op(input logic [N-1:0] av, input logic [N-1:0] bv, input int c0);
        exp_q.push_back(W'(av) * W'(bv));
        exp_cyc_q.push_back(c0 + 1 + run_len(bv));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_ec = exp_cyc_q.pop_front();
                    check("product", product, mon_e);
                    check("done_cycle", cyc, mon_ec);
                    last_prod = mon_e;
                end
            end else begin
                check("product_hold", product, last_prod);
            end
            if (reset) last_prod = '0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!ready && k < 50) begin
            tick();
            k++;
        end
        check("ready_timeout", ready, 1);
    endtask

    task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv, input bit push);
        wait_ready();
        a = av;
        b = bv;
        start = 1'b1;
        if (push) push_op(av, bv, cyc);
        tick();
        start = 1'b0;
        a = N'($urandom_range(0, (1 << N) - 1));
        b = N'($urandom_range(0, (1 << N) - 1));
    endtask

    // ---------------- stimulus ----------------
    logic [N-1:0] hold_a[3];
    logic [N-1:0] hold_b[3];
    int           accepted;
    int           dlen;
    int           k;

    initial begin
        hold_a = '{4'd7, 4'd5, 4'd1};
        hold_b = '{4'd6, 4'd5, 4'd15};

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        tick();
        reset = 1'b0;
        mon_en = 1'b1;

        // 13 x 11 with cycle-accurate handshake checks
        dlen = 1 + run_len(4'd11);
        issue(4'd13, 4'd11, 1'b1);
        for (int c = 1; c <= dlen + 1; c++) begin
            @(negedge clk);
            check("hs_busy", busy, (c <= dlen) ? 1 : 0);
            check("hs_done", done, (c == dlen) ? 1 : 0);
            check("hs_ready", ready, (c == dlen + 1) ? 1 : 0);
        end

        // Boundary operands and early-termination shapes
        issue(4'd15, 4'd15, 1'b1);
        issue(4'd0,  4'd9,  1'b1);
        issue(4'd9,  4'd0,  1'b1);
        issue(4'd9,  4'd1,  1'b1);
        issue(4'd3,  4'd8,  1'b1);
        issue(4'd15, 4'd0,  1'b1);

        // start held high: back-to-back, inputs scrambled while busy
        wait_ready();
        start = 1'b1;
        accepted = 0;
        for (int t = 0; t < 60 && accepted < 3; t++) begin
            if (ready) begin
                a = hold_a[accepted];
                b = hold_b[accepted];
                push_op(hold_a[accepted], hold_b[accepted], cyc);
                accepted++;
            end else begin
                a = N'($urandom_range(0, (1 << N) - 1));
                b = N'($urandom_range(0, (1 << N) - 1));
            end
            tick();
        end
        start = 1'b0;
        check("held_accepts", accepted, 3);

        // Reset during RUN aborts without a done pulse
        issue(4'd12, 4'd12, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", ready, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        repeat (8) tick();
        issue(4'd3, 4'd4, 1'b1);

        // Randomised traffic with idle gaps
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            issue(N'($urandom_range(0, (1 << N) - 1)), N'($urandom_range(0, (1 << N) - 1)), 1'b1);
        end

        // Drain
        k = 0;
        while (exp_q.size() > 0 && k < 100) begin
            tick();
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
